// File: rtl/screen_fill_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | screen_fill_engine_if                                                |
// | Command inputs, processor store port and screen-memory write port    |
// | of the tile fill engine.                                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface screen_fill_engine_if #(
    parameter int ADDRW = 11,
    parameter int CODEW = 4
);
    logic             start_i;
    logic [5:0]       col_i;
    logic [4:0]       row_i;
    logic [5:0]       width_i;
    logic [4:0]       height_i;
    logic [CODEW-1:0] code_i;
    logic             cpu_we_i;
    logic [ADDRW-1:0] cpu_addr_i;
    logic [CODEW-1:0] cpu_data_i;
    logic             mem_we_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [CODEW-1:0] mem_data_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport slave (
        input  start_i, col_i, row_i, width_i, height_i, code_i,
        input  cpu_we_i, cpu_addr_i, cpu_data_i,
        output mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, col_i, row_i, width_i, height_i, code_i,
        output cpu_we_i, cpu_addr_i, cpu_data_i,
        input  mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/screen_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | screen_fill_engine                                                   |
// | Writes one character code into every cell of a tile rectangle, one  |
// | cell per clock, yielding the write port to processor stores.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module screen_fill_engine #(
    parameter int COLS  = 40,
    parameter int ROWS  = 30,
    parameter int ADDRW = 11,
    parameter int CODEW = 4
) (
    input  wire                  clk,
    input  wire                  rst_n,
    screen_fill_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cx_q, cx_d;
    logic [5:0]       col_q, col_d;
    logic [6:0]       end_q, end_d;
    logic [ADDRW-1:0] rowbase_q, rowbase_d;
    logic [4:0]       rows_left_q, rows_left_d;
    logic [CODEW-1:0] code_q, code_d;
    logic             err_q, err_d;

    logic [6:0]       w_col_sum;
    logic [5:0]       w_row_sum;
    logic             w_reject;
    logic [6:0]       w_cx_next;
    logic [ADDRW-1:0] w_eng_addr;

    // Bounds sums are one bit wider than the operands so they cannot wrap.
    assign w_col_sum  = {1'b0, bus.col_i} + {1'b0, bus.width_i};
    assign w_row_sum  = {1'b0, bus.row_i} + {1'b0, bus.height_i};
    assign w_reject   = (bus.width_i == 6'd0) || (bus.height_i == 5'd0) ||
                        (w_col_sum > 7'(COLS)) || (w_row_sum > 6'(ROWS));
    assign w_cx_next  = {1'b0, cx_q} + 7'd1;
    assign w_eng_addr = rowbase_q + ADDRW'(cx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cx_q        <= '0;
            col_q       <= '0;
            end_q       <= '0;
            rowbase_q   <= '0;
            rows_left_q <= '0;
            code_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            col_q       <= col_d;
            end_q       <= end_d;
            rowbase_q   <= rowbase_d;
            rows_left_q <= rows_left_d;
            code_q      <= code_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        col_d       = col_q;
        end_d       = end_q;
        rowbase_d   = rowbase_q;
        rows_left_d = rows_left_q;
        code_d      = code_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (w_reject) begin
                        err_d = 1'b1;
                    end else begin
                        col_d       = bus.col_i;
                        end_d       = w_col_sum;
                        cx_d        = bus.col_i;
                        rowbase_d   = ADDRW'(bus.row_i) * ADDRW'(COLS);
                        rows_left_d = bus.height_i;
                        code_d      = bus.code_i;
                        state_d     = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // A processor store owns the port this cycle; the cursor holds.
                if (!bus.cpu_we_i) begin
                    if (w_cx_next < end_q) begin
                        cx_d = cx_q + 6'd1;
                    end else begin
                        cx_d        = col_q;
                        rowbase_d   = rowbase_q + ADDRW'(COLS);
                        rows_left_d = rows_left_q - 5'd1;
                        if (rows_left_q == 5'd1) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_we_o   = bus.cpu_we_i;
        bus.mem_addr_o = bus.cpu_addr_i;
        bus.mem_data_o = bus.cpu_data_i;
        if (!bus.cpu_we_i && (state_q == ST_FILL)) begin
            bus.mem_we_o   = 1'b1;
            bus.mem_addr_o = w_eng_addr;
            bus.mem_data_o = code_q;
        end
    end

    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.done_o = (state_q == ST_FINISH);
    assign bus.err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_screen_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_screen_fill_engine                                                |
// | Directed commands with a cycle-stamped expected-event scoreboard.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_screen_fill_engine;

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    int   scr [0:1199];

    screen_fill_engine_if #(.ADDRW(11), .CODEW(4)) bus ();

    screen_fill_engine #(
        .COLS(40), .ROWS(30), .ADDRW(11), .CODEW(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int kind, int c, int a, int d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void check_ev(int kind, int a, int d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0d at cycle %0d, expected none",
                     kind, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.addr != a || e.data != d) begin
                n_fail++;
                $display("FAIL event: got kind %0d cyc %0d addr %0d data %0d expected kind %0d cyc %0d addr %0d data %0d",
                         kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endfunction

    // Monitor: every write, done and err the DUT presents is matched in order.
    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            check_ev(K_WR, int'(bus.mem_addr_o), int'(bus.mem_data_o));
            if (bus.mem_addr_o < 11'd1200) scr[bus.mem_addr_o] = int'(bus.mem_data_o);
        end
        if (bus.done_o) check_ev(K_DONE, 0, 0);
        if (bus.err_o)  check_ev(K_ERR, 0, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(int c, int r, int w, int h, int cd);
        bus.col_i    = 6'(c);
        bus.row_i    = 5'(r);
        bus.width_i  = 6'(w);
        bus.height_i = 5'(h);
        bus.code_i   = 4'(cd);
    endtask

    // Issues a start in the current cycle; returns in cycle 1 of the command.
    task automatic issue(int c, int r, int w, int h, int cd, bit ok);
        int k;
        int n;
        k = cyc;
        set_cmd(c, r, w, h, cd);
        bus.start_i = 1'b1;
        if (ok) begin
            n = 0;
            for (int rr = 0; rr < h; rr++) begin
                for (int cc = 0; cc < w; cc++) begin
                    push_ev(K_WR, k + 1 + n, (r + rr) * 40 + c + cc, cd);
                    n++;
                end
            end
            push_ev(K_DONE, k + 1 + n, 0, 0);
        end else begin
            push_ev(K_ERR, k + 1, 0, 0);
        end
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && bus.busy_o; i++) step();
        chk("idle_timeout", int'(bus.busy_o), 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 1200; i++) scr[i] = 15;
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_done", int'(bus.done_o), 0);
        chk("reset_err", int'(bus.err_o), 0);
        chk("reset_we", int'(bus.mem_we_o), 0);

        // Single cell
        issue(0, 0, 1, 1, 5, 1'b1);
        chk("t1_busy_c1", int'(bus.busy_o), 1);
        step();
        chk("t1_busy_c2", int'(bus.busy_o), 1);
        step();
        chk("t1_busy_c3", int'(bus.busy_o), 0);

        // Bottom-right corner rectangle
        issue(37, 28, 3, 2, 9, 1'b1);
        wait_idle();

        // Rejected commands
        issue(38, 0, 3, 1, 4, 1'b0);
        chk("rej_col_busy", int'(bus.busy_o), 0);
        step();
        chk("rej_col_busy2", int'(bus.busy_o), 0);
        issue(0, 29, 1, 2, 4, 1'b0);
        chk("rej_row_busy", int'(bus.busy_o), 0);
        step();
        issue(3, 3, 0, 1, 4, 1'b0);
        chk("rej_w0_busy", int'(bus.busy_o), 0);
        step();
        issue(3, 3, 2, 0, 4, 1'b0);
        step();

        // Processor store stalls the engine for one cycle
        k = cyc;
        set_cmd(0, 0, 2, 1, 6);
        bus.start_i = 1'b1;
        push_ev(K_WR, k + 1, 0, 6);
        push_ev(K_WR, k + 2, 500, 3);
        push_ev(K_WR, k + 3, 1, 6);
        push_ev(K_DONE, k + 4, 0, 0);
        step();
        bus.start_i = 1'b0;
        step();
        bus.cpu_we_i   = 1'b1;
        bus.cpu_addr_i = 11'd500;
        bus.cpu_data_i = 4'd3;
        step();
        bus.cpu_we_i = 1'b0;
        wait_idle();

        // Full screen, with starts during FILL and FINISH that must be ignored
        k = cyc;
        issue(0, 0, 40, 30, 0, 1'b1);
        while (cyc < k + 10) step();
        set_cmd(5, 5, 1, 1, 15);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        while (cyc < k + 1201) step();
        chk("fs_busy_finish", int'(bus.busy_o), 1);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("fs_busy_after", int'(bus.busy_o), 0);
        repeat (4) step();

        // Asynchronous reset in cycle 50 of a full-screen fill
        k = cyc;
        set_cmd(0, 0, 40, 30, 7);
        bus.start_i = 1'b1;
        for (int i = 0; i < 49; i++) push_ev(K_WR, k + 1 + i, i, 7);
        step();
        bus.start_i = 1'b0;
        while (cyc < k + 50) step();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_we", int'(bus.mem_we_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("rst_idle_busy", int'(bus.busy_o), 0);
        chk("mem0_kept", scr[0], 7);
        chk("mem48_kept", scr[48], 7);
        chk("mem49_old", scr[49], 0);
        chk("mem1199_old", scr[1199], 0);

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_fill_engine.md
# screen_fill_engine

Tile-rectangle fill engine that sits directly upstream of the screen memory read by the VGA display driver. On a single start command it writes one 4-bit character code into every cell of a rectangle on the 40x30 tile screen, one cell per clock. It shares the screen memory write port with the processor's direct stores, and processor writes take priority. Games use it to clear or paint regions without per-tile store loops.

## Interface
- COLS, 40, tiles per screen row
- ROWS, 30, tile rows per screen
- ADDRW, 11, screen memory address width
- CODEW, 4, character code width

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- col  in  6  left tile column of rectangle
- row  in  5  top tile row of rectangle
- width  in  6  rectangle width in tiles
- height  in  5  rectangle height in tiles
- code  in  CODEW  character code to write
- cpu_we  in  1  processor screen-memory write enable
- cpu_addr  in  ADDRW  processor write address
- cpu_data  in  CODEW  processor write data
- mem_we  out  1  screen memory write enable
- mem_addr  out  ADDRW  screen memory write address
- mem_data  out  CODEW  screen memory write data
- busy  out  1  command in progress (FILL or FINISH)
- done  out  1  one-cycle pulse after the last cell write
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- States: IDLE, FILL, FINISH.
- IDLE with start=1: latch col, width, code. Perform the bounds check in 7-bit (col+width) and 6-bit (row+height) arithmetic.
  - Reject if width==0, height==0, col+width>COLS, or row+height>ROWS. On reject: err=1 for the next cycle, state stays IDLE, no writes, busy stays 0.
  - Otherwise: load cx=col, rowbase=row*COLS, rows_left=height, and go to FILL.
- FILL: the engine write is addr=rowbase+cx, data=latched code.
  - If cpu_we=0, the write is issued and the cursor advances. If cx+1 < col+width, then cx++. Otherwise cx=col, rowbase+=COLS, rows_left--.
  - After issuing the last cell (last column of the last row), go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- start in FILL or FINISH is ignored. It is not queued.
- Cell order is row-major: left to right, top to bottom. Every address lies in 0..COLS*ROWS-1 (max 1199).
- Write port mux (combinational):
  - cpu_we=1: mem_* = cpu_*. The engine stalls and its cursor holds.
  - else state==FILL: mem_we=1 with the engine address and data.
  - else: mem_we=0. mem_addr and mem_data follow cpu_*.
- Reset (reset_n=0, asynchronous, any state):
  - state goes to IDLE; busy=0, done=0, err=0; cursor registers cleared.
  - The engine stops writing immediately; mem_we follows cpu_we only.
  - Cells written before reset keep their contents.

## Timing
- Start accepted at edge E0. busy=1 and the first write occur in cycle 1 (after E0).
- Without stalls, an N=width*height fill writes in cycles 1..N. done=1 and busy=1 in cycle N+1. busy=0 in cycle N+2, where a new start is accepted.
- Each cpu_we cycle during FILL delays all later engine writes and done by exactly one cycle.
- Throughput is 1 cell/cycle. Latency from start to done is N+1 cycles plus stall cycles.
- err asserts in cycle 1 after a rejected start. A start accepted in cycle 1 is legal.
- done and err are never high together. Neither is high in the same cycle as the other command's acceptance.

## Test plan
- col=0,row=0,w=1,h=1,code=5: single write addr 0 data 5 in cycle 1; done in cycle 2; busy low in cycle 3.
- col=37,row=28,w=3,h=2,code=9: writes to addrs 1157,1158,1159,1197,1198,1199 in cycles 1-6; done in cycle 7.
- Reject cases each produce an err pulse in cycle 1, zero writes, and busy never high:
  - col=38,w=3
  - row=29,h=2
  - w=0
- 2x1 fill at col=0,row=0 with cpu_we=1, cpu_addr=500, cpu_data=3 in cycle 2:
  - cycle 1: addr 0
  - cycle 2: addr 500 data 3
  - cycle 3: addr 1
  - done in cycle 4.
- Full screen 40x30 fill, code=0: 1200 writes to addrs 0..1199 in order; done in cycle 1201; start pulses at cycles 10 and 1201 are ignored.
- reset_n low in cycle 50 of a full-screen fill: busy=0 and mem_we=0 immediately. After release there are no writes until a new start; addrs 0..48 hold code.
